// File: rtl/rom_programmer_pkg.sv
// rom_programmer_pkg: state/operation codes and error codes for the fuse-PROM programmer.
package rom_programmer_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WAIT    = 4'd1,
    S_READ    = 4'd2,
    S_CHECK   = 4'd3,
    S_PULSE   = 4'd4,
    S_RECOVER = 4'd5,
    S_VERIFY  = 4'd6,
    S_NEXT    = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_BLOWN = 2'd2;
  localparam logic [1:0] ERR_RETRY = 2'd3;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/rom_prog_timer.sv
// rom_prog_timer: loadable down-counter; expired while the count sits at zero.
module rom_prog_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/rom_programmer.sv
// rom_programmer: burns a host byte stream into a bipolar fuse PROM one fuse at a time,
// with timed pulse, recovery, read-back verify and bounded retries.
module rom_programmer
  import rom_programmer_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDRESS_WIDTH  = 9,
  parameter int                    PULSE_CYCLES   = 50,
  parameter int                    RECOVER_CYCLES = 20,
  parameter int                    READ_CYCLES    = 4,
  parameter int                    MAX_RETRIES    = 3,
  parameter logic [DATA_WIDTH-1:0] BLANK_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH-1:0] end_address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line,
  output logic                     data_oe,
  output logic                     prog_pulse,
  output logic                     chip_select_n,
  output logic [3:0]               operation,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               error_code
);
  localparam int TMAX = max3(PULSE_CYCLES, RECOVER_CYCLES, READ_CYCLES);
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(MAX_RETRIES + 2);
  state_t                  state, nxt;
  logic [DATA_WIDTH-1:0]   target, current, sel, need, low;
  logic [ADDRESS_WIDTH-1:0] end_addr;
  logic [RW-1:0]           retries;
  logic [1:0]              ec_nxt;
  logic [TW-1:0]           load_value;
  logic                    expired, blown, match, bad_range, give_up;
  assign need      = target ^ current;
  assign low       = need & (~need + 1'b1);
  assign blown     = |(need & (current ^ BLANK_VALUE));
  assign match     = ((data_line_in ^ target) & sel) == '0;
  assign bad_range = end_address < start_address;
  assign give_up   = retries >= RW'(MAX_RETRIES);
  assign load_value = nxt == S_PULSE   ? TW'(PULSE_CYCLES - 1) :
                      nxt == S_RECOVER ? TW'(RECOVER_CYCLES - 1) : TW'(READ_CYCLES - 1);
  rom_prog_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (nxt != state),
    .load_value (load_value),
    .expired    (expired)
  );
  always_comb begin
    nxt    = state;
    ec_nxt = error_code;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) begin
        nxt    = bad_range ? S_ERROR : S_WAIT;
        ec_nxt = bad_range ? ERR_RANGE : ERR_NONE;
      end
      S_WAIT:    if (data_valid) nxt = S_READ;
      S_READ:    if (expired) nxt = S_CHECK;
      S_CHECK: begin
        nxt    = blown ? S_ERROR : need == '0 ? S_NEXT : S_PULSE;
        ec_nxt = blown ? ERR_BLOWN : error_code;
      end
      S_PULSE:   if (expired) nxt = S_RECOVER;
      S_RECOVER: if (expired) nxt = S_VERIFY;
      S_VERIFY:  if (expired) begin
        nxt    = match ? S_CHECK : give_up ? S_ERROR : S_PULSE;
        ec_nxt = !match && give_up ? ERR_RETRY : error_code;
      end
      S_NEXT:    nxt = address_line == end_addr ? S_DONE : S_WAIT;
      default:   nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt    = S_IDLE;
      ec_nxt = error_code;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= S_IDLE;
      operation     <= '0;
      data_ready    <= 1'b0;
      prog_pulse    <= 1'b0;
      data_oe       <= 1'b0;
      data_line     <= '0;
      chip_select_n <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      error_code    <= ERR_NONE;
      address_line  <= '0;
      end_addr      <= '0;
      target        <= '0;
      current       <= '0;
      sel           <= '0;
      retries       <= '0;
    end else begin
      state         <= nxt;
      operation     <= nxt;
      data_ready    <= nxt == S_WAIT;
      prog_pulse    <= nxt == S_PULSE;
      data_oe       <= nxt == S_PULSE;
      data_line     <= nxt == S_PULSE ? (state == S_CHECK ? low : sel) : '0;
      chip_select_n <= !(nxt inside {S_READ, S_PULSE, S_RECOVER, S_VERIFY});
      done          <= nxt == S_DONE;
      error         <= nxt == S_ERROR;
      error_code    <= ec_nxt;
      if (nxt == S_WAIT && state inside {S_IDLE, S_DONE, S_ERROR}) begin
        address_line <= start_address;
        end_addr     <= end_address;
      end
      if (state == S_WAIT && data_valid) target <= data_in;
      if (state inside {S_READ, S_VERIFY} && expired) current <= data_line_in;
      // a fresh bit selection always restarts the retry budget
      if (state == S_CHECK) begin
        sel     <= low;
        retries <= '0;
      end
      if (state == S_VERIFY && nxt == S_PULSE) retries <= retries + 1'b1;
      if (state == S_NEXT && nxt == S_WAIT) address_line <= address_line + 1'b1;
    end
endmodule

// File: tb/tb_rom_programmer.sv
// tb_rom_programmer: directed bench with a fuse-chip model and a pulse-sequence scoreboard.
module tb_rom_programmer;
  logic       clk = 0, reset_n = 0, start = 0, abort = 0, data_valid = 0;
  logic [8:0] start_address = 0, end_address = 0, address_line;
  logic [7:0] data_in = 0, data_line_in, data_line;
  logic       data_ready, data_oe, prog_pulse, chip_select_n, done, error;
  logic [3:0] operation;
  logic [1:0] error_code;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] mem [512];
  int         pcnt [512*8];
  int         n_fuse = 1;
  logic [7:0] tgt [$];
  int         exp_q [$];
  int         pulse_log [$];
  int         exp_err, exp_addr, feed_k, width;
  bit         prev_pulse = 0, ok;

  rom_programmer #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(9), .PULSE_CYCLES(4), .RECOVER_CYCLES(2),
    .READ_CYCLES(2), .MAX_RETRIES(2), .BLANK_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .start_address(start_address), .end_address(end_address),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .data_line_in(data_line_in), .address_line(address_line), .data_line(data_line),
    .data_oe(data_oe), .prog_pulse(prog_pulse), .chip_select_n(chip_select_n),
    .operation(operation), .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;
  assign data_line_in = chip_select_n ? 8'h00 : mem[address_line];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Outputs implied by the operation code, and every pulse window checked against the expected sequence
  always @(negedge clk) begin
    chk("ready_vs_op", int'(data_ready), int'(operation == 4'd1));
    chk("done_vs_op", int'(done), int'(operation == 4'd8));
    chk("error_vs_op", int'(error), int'(operation == 4'd9));
    chk("oe_vs_op", int'(data_oe), int'(operation == 4'd4));
    chk("pulse_vs_op", int'(prog_pulse), int'(operation == 4'd4));
    chk("cs_vs_op", int'(chip_select_n), int'(!(operation inside {4'd2, 4'd4, 4'd5, 4'd6})));
    chk("fuse_select", int'(prog_pulse ? $onehot(data_line) : data_line == 8'h00), 1);
    if (prog_pulse && !prev_pulse) begin
      pulse_log.push_back(int'(address_line) * 256 + int'(data_line));
      chk("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("pulse_target", int'(address_line) * 256 + int'(data_line), exp_q.pop_front());
      for (int i = 0; i < 8; i++) if (data_line[i]) begin
        pcnt[int'(address_line) * 8 + i]++;
        if (pcnt[int'(address_line) * 8 + i] == n_fuse) mem[address_line][i] = 1'b1;
      end
      width = 1;
    end else if (prog_pulse) width++;
    if (!prog_pulse && prev_pulse && operation == 4'd5) chk("pulse_width", width, 4);
    prev_pulse = prog_pulse;
  end

  task automatic clear_chip(input int n);
    for (int a = 0; a < 512; a++) mem[a] = 8'h00;
    for (int a = 0; a < 512 * 8; a++) pcnt[a] = 0;
    n_fuse = n;
    pulse_log.delete();
  endtask

  task automatic build_model(input int sa, input int ea);
    logic [7:0] cur, need;
    exp_q.delete();
    exp_err = 0;
    exp_addr = ea;
    for (int a = sa; a <= ea; a++) begin
      cur = mem[a];
      need = tgt[a - sa] ^ cur;
      if ((need & cur) != 8'h00) begin
        exp_err = 2; exp_addr = a; return;
      end
      for (int i = 0; i < 8; i++) if (need[i]) begin
        for (int p = 0; p < (n_fuse < 3 ? n_fuse : 3); p++) exp_q.push_back(a * 256 + (1 << i));
        if (n_fuse > 3) begin
          exp_err = 3; exp_addr = a; return;
        end
      end
    end
  endtask

  task automatic start_job(input logic [8:0] sa, input logic [8:0] ea);
    build_model(int'(sa), int'(ea));
    feed_k = 0;
    @(negedge clk);
    start_address = sa; end_address = ea; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_for(input bit for_pulse, output bit hit);
    hit = 0;
    for (int c = 0; c < 3000; c++) begin
      data_valid = 0;
      if (for_pulse ? prog_pulse : (done || error)) begin
        hit = 1; break;
      end
      if (data_ready && feed_k < tgt.size()) begin
        data_valid = 1; data_in = tgt[feed_k]; feed_k++;
      end
      @(negedge clk);
    end
    data_valid = 0;
  endtask

  task automatic run(input logic [8:0] sa, input logic [8:0] ea);
    start_job(sa, ea);
    wait_for(0, ok);
    chk("job_finished", int'(ok), 1);
    chk("job_done", int'(done), int'(exp_err == 0));
    chk("job_error_code", int'(error_code), exp_err);
    chk("job_address", int'(address_line), exp_addr);
    chk("pulses_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_op", int'(operation), 0);
    chk("rst_cs_n", int'(chip_select_n), 1);
    chk("rst_pulse", int'(prog_pulse), 0);
    chk("rst_addr", int'(address_line), 0);
    chk("rst_err", int'({done, error, error_code, data_ready, data_oe}), 0);

    clear_chip(1); tgt = '{8'hA5};
    run(9'h000, 9'h000);
    chk("a5_count", pulse_log.size(), 4);
    if (pulse_log.size() == 4) begin
      chk("a5_bit0", pulse_log[0], 'h001);
      chk("a5_bit2", pulse_log[1], 'h004);
      chk("a5_bit5", pulse_log[2], 'h020);
      chk("a5_bit7", pulse_log[3], 'h080);
    end
    chk("a5_done", int'({done, error}), 2);

    clear_chip(1); tgt = '{8'h01, 8'h00};
    run(9'h1FE, 9'h1FF);
    chk("top_count", pulse_log.size(), 1);
    if (pulse_log.size() == 1) chk("top_pulse", pulse_log[0], 'h1FE01);
    chk("top_addr", int'(address_line), 'h1FF);
    chk("top_done", int'(done), 1);

    clear_chip(1); mem[0] = 8'h02; tgt = '{8'h01};
    run(9'h000, 9'h000);
    chk("blown_code", int'(error_code), 2);
    chk("blown_pulses", pulse_log.size(), 0);

    clear_chip(5); tgt = '{8'h01};
    run(9'h000, 9'h000);
    chk("stubborn_pulses", pulse_log.size(), 3);
    chk("stubborn_code", int'(error_code), 3);

    clear_chip(3); tgt = '{8'h01};
    run(9'h000, 9'h000);
    chk("third_pulses", pulse_log.size(), 3);
    chk("third_done", int'({done, error}), 2);

    clear_chip(1); tgt = '{8'hA5};
    start_job(9'h000, 9'h000);
    wait_for(1, ok);
    chk("abort_reached_pulse", int'(ok), 1);
    @(negedge clk);
    chk("abort_pre", int'(prog_pulse), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_pulse", int'(prog_pulse), 0);
    chk("abort_op", int'(operation), 0);
    chk("abort_drive", int'({data_oe, chip_select_n, data_line}), 'h100);
    exp_q.delete();

    clear_chip(1); tgt = '{8'hA5};
    start_job(9'h000, 9'h000);
    wait_for(1, ok);
    chk("rst_reached_pulse", int'(ok), 1);
    @(negedge clk);
    #1 reset_n = 0;
    #1 chk("rst_async_pulse", int'(prog_pulse), 0);
    chk("rst_async_op", int'(operation), 0);
    @(negedge clk);
    reset_n = 1;
    exp_q.delete();

    @(negedge clk);
    start_address = 9'h010; end_address = 9'h00F; start = 1;
    @(negedge clk);
    start = 0;
    chk("range_op", int'(operation), 9);
    chk("range_code", int'(error_code), 1);
    chk("range_ready", int'(data_ready), 0);
    start_address = 9'h000; end_address = 9'h000; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("abort_wins_op", int'(operation), 0);
    chk("abort_wins_ready", int'(data_ready), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
